// File: rtl/reg_pkg.sv
// Shared sizing and types for the register-bank read stage.
// Ports: none (package only).
// Widths: 32-bit operands, 32 registers, register 0 is hard zero.
package reg_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int NUM_REG      = 32;
  localparam int SELECT_WIDTH = $clog2(NUM_REG);

  typedef logic [SELECT_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]   word_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register; bit 0 is always 0.
// Ports: set_en/set_idx mark a register busy, clr_en/clr_idx release it, busy is the vector.
// Latency: one cycle (registered). A set and a clear on the same index in one cycle leaves it busy.
module reg_scoreboard
  import reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  reg_idx_t           set_idx,
  input  logic               clr_en,
  input  reg_idx_t           clr_idx,
  output logic [NUM_REG-1:0] busy
);

  logic [NUM_REG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NUM_REG; r++) begin
      // Clear applied first so a same-index set overrides it.
      if (clr_en && clr_idx == reg_idx_t'(r)) busy_nxt[r] = 1'b0;
      if (set_en && set_idx == reg_idx_t'(r)) busy_nxt[r] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/reg_read_stage.sv
// Operand-fetch stage: selects rs1/rs2 from the bank read array, registers them for execute.
// Ports: decode side i_valid/o_ready + rs1/rs2/rd fields; execute side o_valid/i_ready + operands;
//        writeback i_wb_* clears the scoreboard. Latency one cycle; stalls on scoreboard hazards.
// Option: FORWARD_EN bypasses same-cycle writeback data into the operands and exempts that
//         register from the hazard check; without it a dependency waits until after the commit.
module reg_read_stage
  import reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  word_t       i_read_data [NUM_REG],
  input  logic        i_valid,
  output logic        o_ready,
  input  reg_idx_t    i_rs1,
  input  reg_idx_t    i_rs2,
  input  reg_idx_t    i_rd,
  input  logic        i_rd_write,
  output logic        o_valid,
  input  logic        i_ready,
  output word_t       o_rs1_data,
  output word_t       o_rs2_data,
  output reg_idx_t    o_rd,
  output logic        o_rd_write,
  input  logic        i_wb_enable,
  input  reg_idx_t    i_wb_select,
  input  word_t       i_wb_data
);

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic [NUM_REG-1:0] busy;
  logic               hazard;
  logic               accept;
  logic               set_en;

  // Writeback in this cycle targets idx and can be bypassed.
  function automatic logic wb_hit(input reg_idx_t idx);
    return FWD && i_wb_enable && (i_wb_select == idx);
  endfunction

  function automatic logic reg_busy(input reg_idx_t idx);
    return (idx != '0) && busy[idx] && !wb_hit(idx);
  endfunction

  function automatic word_t operand(input reg_idx_t idx);
    if (idx == '0)       return '0;
    else if (wb_hit(idx)) return i_wb_data;
    else                  return i_read_data[idx];
  endfunction

  // Destination term blocks WAW; reg_busy already excludes index 0.
  assign hazard  = reg_busy(i_rs1) || reg_busy(i_rs2) || (i_rd_write && reg_busy(i_rd));
  assign o_ready = (!o_valid || i_ready) && !hazard;
  assign accept  = i_valid && o_ready;
  assign set_en  = accept && i_rd_write && (i_rd != '0);

  reg_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_idx (i_rd),
    .clr_en  (i_wb_enable),
    .clr_idx (i_wb_select),
    .busy    (busy)
  );

  // Operands are captured only on accept, so a held output never re-reads the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
      o_rd       <= '0;
      o_rd_write <= 1'b0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_rs1_data <= operand(i_rs1);
      o_rs2_data <= operand(i_rs2);
      o_rd       <= i_rd;
      o_rd_write <= i_rd_write;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage; works with or without FORWARD_EN defined.
module tb_reg_read_stage;
  import reg_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  word_t    rd_data [NUM_REG];
  logic     i_valid = 1'b0, i_rd_write = 1'b0, i_ready = 1'b1, i_wb_enable = 1'b0;
  reg_idx_t i_rs1 = '0, i_rs2 = '0, i_rd = '0, i_wb_select = '0;
  word_t    i_wb_data = '0;
  logic     o_ready, o_valid, o_rd_write;
  word_t    o_rs1_data, o_rs2_data;
  reg_idx_t o_rd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk(clk), .rst(rst), .i_read_data(rd_data),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_rd_write(i_rd_write),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_rd(o_rd), .o_rd_write(o_rd_write),
    .i_wb_enable(i_wb_enable), .i_wb_select(i_wb_select), .i_wb_data(i_wb_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd, input logic wr);
    i_valid    = 1'b1;
    i_rs1      = reg_idx_t'(rs1);
    i_rs2      = reg_idx_t'(rs2);
    i_rd       = reg_idx_t'(rd);
    i_rd_write = wr;
  endtask

  initial begin
    for (int i = 0; i < NUM_REG; i++) rd_data[i] = 32'h1000 + i;
    rd_data[0] = '0;
    tick();
    tick();
    check("reset_o_valid", {31'b0, o_valid}, 32'd0);
    check("reset_o_rd_write", {31'b0, o_rd_write}, 32'd0);
    check("reset_busy", dut.busy, 32'd0);
    rst = 1'b0;
    #1;
    check("reset_o_ready", {31'b0, o_ready}, 32'd1);

    // Back-to-back independent issues.
    issue(1, 2, 0, 1'b0);
    #1 check("b2b_ready0", {31'b0, o_ready}, 32'd1);
    tick();
    check("b2b_valid0", {31'b0, o_valid}, 32'd1);
    check("b2b_rs1_0", o_rs1_data, 32'h1001);
    check("b2b_rs2_0", o_rs2_data, 32'h1002);
    issue(3, 4, 0, 1'b0);
    #1 check("b2b_ready1", {31'b0, o_ready}, 32'd1);
    tick();
    check("b2b_rs1_1", o_rs1_data, 32'h1003);
    check("b2b_rs2_1", o_rs2_data, 32'h1004);
    i_valid = 1'b0;
    tick();
    check("drain_valid", {31'b0, o_valid}, 32'd0);

    // Register 0 reads as zero even if the bank says otherwise; rd=0 never goes busy.
    rd_data[0] = 32'h0000_FFFF;
    issue(0, 0, 0, 1'b1);
    tick();
    check("zero_rs1", o_rs1_data, 32'd0);
    check("zero_rs2", o_rs2_data, 32'd0);
    check("zero_rd_write", {31'b0, o_rd_write}, 32'd1);
    check("zero_busy", dut.busy, 32'd0);
    rd_data[0] = '0;
    i_valid = 1'b0;
    tick();

    // Downstream stall holds outputs; bank changes ignored.
    i_ready = 1'b0;
    issue(6, 8, 3, 1'b0);
    tick();
    i_valid = 1'b0;
    rd_data[6] = 32'hBEEF;
    for (int c = 0; c < 3; c++) begin
      check("hold_valid", {31'b0, o_valid}, 32'd1);
      check("hold_rs1", o_rs1_data, 32'h1006);
      check("hold_rs2", o_rs2_data, 32'h1008);
      check("hold_rd", {27'b0, o_rd}, 32'd3);
      check("hold_ready", {31'b0, o_ready}, 32'd0);
      tick();
    end
    rd_data[6] = 32'h1006;
    i_ready = 1'b1;
    tick();
    check("hold_release", {31'b0, o_valid}, 32'd0);

    // RAW on rd=5, resolved by writeback of 0xDEAD.
    issue(1, 2, 5, 1'b1);
    tick();
    check("raw_busy5", dut.busy, 32'h0000_0020);
    issue(5, 0, 0, 1'b0);
    #1 check("raw_stall0", {31'b0, o_ready}, 32'd0);
    tick();
    tick();
    check("raw_stall1", {31'b0, o_ready}, 32'd0);
    i_wb_enable = 1'b1;
    i_wb_select = 5'd5;
    i_wb_data   = 32'hDEAD;
    #1;
`ifdef FORWARD_EN
    check("raw_wb_ready", {31'b0, o_ready}, 32'd1);
    tick();
    i_wb_enable = 1'b0;
    rd_data[5]  = 32'hDEAD;
    check("raw_fwd_valid", {31'b0, o_valid}, 32'd1);
    check("raw_fwd_rs1", o_rs1_data, 32'hDEAD);
`else
    check("raw_wb_ready", {31'b0, o_ready}, 32'd0);
    tick();
    i_wb_enable = 1'b0;
    rd_data[5]  = 32'hDEAD;
    #1 check("raw_after_ready", {31'b0, o_ready}, 32'd1);
    tick();
    check("raw_valid", {31'b0, o_valid}, 32'd1);
    check("raw_rs1", o_rs1_data, 32'hDEAD);
`endif
    check("raw_busy_clear", dut.busy, 32'd0);
    i_valid = 1'b0;
    tick();

    // WAW on rd=7 coinciding with its writeback.
    issue(1, 2, 7, 1'b1);
    tick();
    check("waw_busy7", dut.busy, 32'h0000_0080);
    i_wb_enable = 1'b1;
    i_wb_select = 5'd7;
    i_wb_data   = 32'h77;
    #1;
`ifdef FORWARD_EN
    check("waw_ready", {31'b0, o_ready}, 32'd1);
    tick();
    i_wb_enable = 1'b0;
    check("waw_set_wins", dut.busy, 32'h0000_0080);
    check("waw_valid", {31'b0, o_valid}, 32'd1);
`else
    check("waw_ready", {31'b0, o_ready}, 32'd0);
    tick();
    i_wb_enable = 1'b0;
    check("waw_cleared", dut.busy, 32'd0);
    check("waw_ready_after", {31'b0, o_ready}, 32'd1);
    tick();
    check("waw_reset_busy", dut.busy, 32'h0000_0080);
`endif

    // Reset mid-stream: rd=5 pending and o_valid high.
    issue(1, 2, 5, 1'b1);
    tick();
    check("mid_busy", dut.busy, 32'h0000_00A0);
    check("mid_valid", {31'b0, o_valid}, 32'd1);
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, o_valid}, 32'd0);
    check("arst_busy", dut.busy, 32'd0);
    check("arst_rs1", o_rs1_data, 32'd0);
    #1 rst = 1'b0;
    issue(5, 0, 0, 1'b0);
    #1 check("arst_ready", {31'b0, o_ready}, 32'd1);
    tick();
    check("arst_accept", {31'b0, o_valid}, 32'd1);
    check("arst_rs1_val", o_rs1_data, 32'hDEAD);
    i_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
